// File: rtl/vpu_pkg.sv
// Shared VPU sprite types: OAM entry layout, evaluator state encoding and size decode.
package vpu_pkg;

  typedef struct packed {
    logic [7:0]  flag;
    logic [1:0]  palInfo_mode;
    logic [1:0]  palInfo_bank;
    logic [3:0]  palInfo_no;
    logic [3:0]  tileIdx;
    logic [5:0]  tileNo;
    logic [1:0]  tileSize;
    logic [3:0]  _reserved2;
    logic [15:0] x;
    logic [15:0] y;
  } sprite_t;

  typedef enum logic [1:0] {
    EVAL_IDLE,
    EVAL_SCAN,
    EVAL_DRAIN,
    EVAL_DONE
  } eval_state_t;

  // 0->8, 1->16, 2->32, 3->64 pixels
  function automatic logic [6:0] tile_size_px(input logic [1:0] tile_size);
    return 7'd8 << tile_size;
  endfunction

endpackage

// File: rtl/vpu_sprite_eval_if.sv
// OAM read port, slot-list write port and line control/status of the sprite evaluator.
interface vpu_sprite_eval_if #(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8
);
  import vpu_pkg::*;

  localparam int IDX_W  = $clog2(NUM_SPRITES);
  localparam int SLOT_W = $clog2(MAX_PER_LINE);

  logic              line_start;
  logic [8:0]        next_y;
  logic              oam_rd_en;
  logic [IDX_W-1:0]  oam_addr;
  sprite_t           oam_rd_data;
  logic              slot_wr_en;
  logic [SLOT_W-1:0] slot_idx;
  logic [IDX_W-1:0]  slot_sprite;
  logic [5:0]        slot_row;
  logic              busy;
  logic              list_valid;
  logic [SLOT_W:0]   list_count;
  logic              overflow;

  modport master (
    input  line_start, next_y, oam_rd_data,
    output oam_rd_en, oam_addr, slot_wr_en, slot_idx, slot_sprite, slot_row,
           busy, list_valid, list_count, overflow
  );

  modport slave (
    output line_start, next_y, oam_rd_data,
    input  oam_rd_en, oam_addr, slot_wr_en, slot_idx, slot_sprite, slot_row,
           busy, list_valid, list_count, overflow
  );

endinterface

// File: rtl/vpu_sprite_hit.sv
// Combinational vertical hit test of one sprite against a scanline, plus row within the sprite.
module vpu_sprite_hit
  import vpu_pkg::*;
(
  input  sprite_t    spr_i,
  input  logic [8:0] line_y_i,
  output logic       hit_o,
  output logic [5:0] row_o
);

  logic [16:0] line_y;
  logic [16:0] spr_top;
  logic [16:0] spr_end;

  // 17-bit sums so a sprite near y=0xFFFF can never wrap onto low lines
  assign line_y  = {8'd0, line_y_i};
  assign spr_top = {1'b0, spr_i.y};
  assign spr_end = spr_top + {10'd0, tile_size_px(spr_i.tileSize)};

  assign hit_o = spr_i.flag[0] && (spr_top <= line_y) && (line_y < spr_end);
  assign row_o = line_y_i[5:0] - spr_i.y[5:0];

  logic unused_fields;
  assign unused_fields = ^{spr_i.flag[7:1], spr_i.palInfo_mode, spr_i.palInfo_bank,
                           spr_i.palInfo_no, spr_i.tileIdx, spr_i.tileNo,
                           spr_i._reserved2, spr_i.x};

endmodule

// File: rtl/vpu_sprite_eval.sv
// Per-scanline sprite evaluator: scans OAM in index order, one read per cycle, and fills the
// slot list with up to MAX_PER_LINE hits; list_valid NUM_SPRITES+2 cycles after line_start.
module vpu_sprite_eval
  import vpu_pkg::*;
#(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  vpu_sprite_eval_if.master  bus
);

  localparam int IDX_W  = $clog2(NUM_SPRITES);
  localparam int SLOT_W = $clog2(MAX_PER_LINE);
  localparam int CNT_W  = SLOT_W + 1;

  eval_state_t      state_q, state_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0] eval_idx_q, eval_idx_d;
  logic             eval_vld_q, eval_vld_d;
  logic [8:0]       y_q, y_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             rd_en;
  logic             wr_en;
  logic             hit;
  logic [5:0]       row;

  vpu_sprite_hit u_hit (
    .spr_i    (bus.oam_rd_data),
    .line_y_i (y_q),
    .hit_o    (hit),
    .row_o    (row)
  );

  assign rd_en = (state_q == EVAL_SCAN);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    eval_idx_d = addr_q;
    eval_vld_d = 1'b0;
    y_d        = y_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;

    if (bus.line_start) begin
      // Restart from any state; data already in flight is dropped via eval_vld
      state_d = EVAL_SCAN;
      addr_d  = '0;
      y_d     = bus.next_y;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      eval_vld_d = rd_en;
      case (state_q)
        EVAL_SCAN: begin
          if (addr_q == IDX_W'(NUM_SPRITES - 1)) state_d = EVAL_DRAIN;
          else                                   addr_d  = addr_q + IDX_W'(1);
        end
        EVAL_DRAIN: state_d = EVAL_DONE;
        default: ;
      endcase

      if (eval_vld_q && hit) begin
        if (count_q < CNT_W'(MAX_PER_LINE)) begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
        end else begin
          ovf_d      = 1'b1;
          state_d    = EVAL_DONE;
          eval_vld_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EVAL_IDLE;
      addr_q     <= '0;
      eval_idx_q <= '0;
      eval_vld_q <= 1'b0;
      y_q        <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      eval_idx_q <= eval_idx_d;
      eval_vld_q <= eval_vld_d;
      y_q        <= y_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.oam_rd_en   = rd_en;
  assign bus.oam_addr    = addr_q;
  assign bus.slot_wr_en  = wr_en;
  assign bus.slot_idx    = wr_en ? count_q[SLOT_W-1:0] : '0;
  assign bus.slot_sprite = wr_en ? eval_idx_q : '0;
  assign bus.slot_row    = wr_en ? row : '0;
  assign bus.busy        = (state_q == EVAL_SCAN) || (state_q == EVAL_DRAIN);
  assign bus.list_valid  = (state_q == EVAL_DONE);
  assign bus.list_count  = count_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_vpu_sprite_eval.sv
// Directed and randomized OAM tables scored against a list-building reference model.
module tb_vpu_sprite_eval;
  import vpu_pkg::*;

  localparam int NS = 64;
  localparam int MP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpu_sprite_eval_if #(.NUM_SPRITES(NS), .MAX_PER_LINE(MP)) bus();

  vpu_sprite_eval #(.NUM_SPRITES(NS), .MAX_PER_LINE(MP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // OAM: registered read, garbage on idle cycles
  sprite_t oam [NS];
  always @(posedge clk) begin
    if (bus.oam_rd_en) bus.oam_rd_data <= oam[bus.oam_addr];
    else               bus.oam_rd_data <= {$urandom, $urandom};
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk OAM in index order and build the expected list
  int exp_spr[$];
  int exp_row[$];
  int exp_ovf, exp_last_rd, exp_done;

  function automatic void ref_model(input int y);
    exp_spr.delete();
    exp_row.delete();
    exp_ovf = 0;
    exp_last_rd = NS;
    exp_done = NS + 2;
    for (int k = 0; k < NS; k++) begin
      int top;
      int sz;
      top = int'(oam[k].y);
      sz  = 8 << oam[k].tileSize;
      if (oam[k].flag[0] && y >= top && y < top + sz) begin
        if (exp_spr.size() == MP) begin
          exp_ovf = 1;
          exp_last_rd = (k + 2 < NS) ? k + 2 : NS;
          exp_done = k + 3;
          break;
        end
        exp_spr.push_back(k);
        exp_row.push_back(y - top);
      end
    end
  endfunction

  typedef struct {
    int cyc;
    int idx;
    int spr;
    int row;
  } wr_t;

  wr_t got[$];
  int  done_cyc, addr_err, abort_wr;

  task automatic start_line(input int y);
    @(negedge clk);
    bus.line_start = 1'b1;
    bus.next_y = 9'(y);
    @(posedge clk);
    #1 bus.line_start = 1'b0;
  endtask

  // Runs one line; optionally restarts with y2 at cycle abort_at. Cycle numbering restarts at the abort.
  task automatic run_scan(input int y, input int abort_at, input int y2);
    int  c;
    bit  aborted;
    bit  exp_rd;
    got.delete();
    addr_err = 0;
    done_cyc = -1;
    abort_wr = 0;
    aborted = 0;
    c = 0;
    start_line(y);
    for (int n = 0; n < 300 && done_cyc < 0; n++) begin
      @(negedge clk);
      c++;
      if (!aborted && abort_at > 0 && c == abort_at) begin
        bus.line_start = 1'b1;
        bus.next_y = 9'(y2);
        aborted = 1;
        #1 abort_wr = int'(bus.slot_wr_en);
        @(posedge clk);
        #1 bus.line_start = 1'b0;
        got.delete();
        addr_err = 0;
        c = 0;
      end else begin
        exp_rd = (c >= 1 && c <= exp_last_rd);
        if (bus.oam_rd_en !== exp_rd) addr_err++;
        else if (exp_rd && int'(bus.oam_addr) != c - 1) addr_err++;
        if (bus.slot_wr_en)
          got.push_back('{c, int'(bus.slot_idx), int'(bus.slot_sprite), int'(bus.slot_row)});
        if (bus.list_valid) done_cyc = c;
      end
    end
  endtask

  task automatic check_scan(input string tag);
    int n;
    check({tag, ".done_cycle"}, done_cyc, exp_done);
    check({tag, ".addr_seq_errs"}, addr_err, 0);
    check({tag, ".writes"}, got.size(), exp_spr.size());
    n = (got.size() < exp_spr.size()) ? got.size() : exp_spr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.w%0d.cycle", tag, i), got[i].cyc, exp_spr[i] + 2);
      check($sformatf("%s.w%0d.slot", tag, i), got[i].idx, i);
      check($sformatf("%s.w%0d.sprite", tag, i), got[i].spr, exp_spr[i]);
      check($sformatf("%s.w%0d.row", tag, i), got[i].row, exp_row[i]);
    end
    check({tag, ".list_count"}, int'(bus.list_count), exp_spr.size());
    check({tag, ".overflow"}, int'(bus.overflow), exp_ovf);
    check({tag, ".busy"}, int'(bus.busy), 0);
  endtask

  task automatic clear_oam();
    for (int k = 0; k < NS; k++) oam[k] = sprite_t'({$urandom, $urandom});
    for (int k = 0; k < NS; k++) oam[k].flag[0] = 1'b0;
  endtask

  task automatic set_spr(input int k, input int y, input int sz);
    oam[k].flag[0]  = 1'b1;
    oam[k].y        = 16'(y);
    oam[k].tileSize = 2'(sz);
  endtask

  initial begin
    bus.line_start = 1'b0;
    bus.next_y = '0;
    clear_oam();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.list_valid", int'(bus.list_valid), 0);
    check("rst.list_count", int'(bus.list_count), 0);
    check("rst.overflow", int'(bus.overflow), 0);
    check("rst.oam_rd_en", int'(bus.oam_rd_en), 0);
    check("rst.oam_addr", int'(bus.oam_addr), 0);
    check("rst.slot_wr_en", int'(bus.slot_wr_en), 0);
    rst_n = 1'b1;

    // Nothing enabled
    ref_model(10);
    run_scan(10, 0, 0);
    check_scan("empty");

    // 17-bit sum: a sprite at y=0xFFF0 must not wrap onto line 20
    set_spr(1, 16'hFFF0, 3);
    ref_model(20);
    run_scan(20, 0, 0);
    check_scan("nowrap");

    // Single 16-line sprite, last row and one past it
    clear_oam();
    set_spr(5, 100, 1);
    ref_model(115);
    run_scan(115, 0, 0);
    check_scan("single_in");
    ref_model(116);
    run_scan(116, 0, 0);
    check_scan("single_out");

    // Ten hits: eight slots, overflow on sprite 8, early finish
    clear_oam();
    for (int k = 0; k < 10; k++) set_spr(k, 20, 0);
    ref_model(27);
    run_scan(27, 0, 0);
    check_scan("overflow");

    // Only the last sprite hits, at its bottom row
    clear_oam();
    set_spr(63, 0, 3);
    ref_model(63);
    run_scan(63, 0, 0);
    check_scan("last_sprite");

    // Restart mid-scan: sprite 18 hits the old line exactly in the abort cycle
    clear_oam();
    set_spr(18, 30, 0);
    set_spr(40, 200, 1);
    ref_model(205);
    run_scan(33, 20, 205);
    check("abort.no_write", abort_wr, 0);
    check_scan("abort");

    // Reset mid-scan while a write is on the bus
    clear_oam();
    set_spr(2, 40, 0);
    set_spr(10, 40, 0);
    set_spr(28, 40, 0);
    start_line(41);
    repeat (30) @(negedge clk);
    check("midrst.pre_wr", int'(bus.slot_wr_en), 1);
    check("midrst.pre_count", int'(bus.list_count), 2);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", int'(bus.busy), 0);
    check("midrst.list_valid", int'(bus.list_valid), 0);
    check("midrst.list_count", int'(bus.list_count), 0);
    check("midrst.slot_wr_en", int'(bus.slot_wr_en), 0);
    check("midrst.oam_rd_en", int'(bus.oam_rd_en), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_model(41);
    run_scan(41, 0, 0);
    check_scan("after_rst");

    // Randomized tables around a random target line
    for (int it = 0; it < 8; it++) begin
      int y;
      int pct;
      y = $urandom_range(0, 260);
      pct = $urandom_range(5, 60);
      clear_oam();
      for (int k = 0; k < NS; k++) begin
        if ($urandom_range(0, 99) < pct) begin
          if ($urandom_range(0, 7) == 0) set_spr(k, $urandom_range(300, 65535), $urandom_range(0, 3));
          else set_spr(k, (y > 70) ? y - $urandom_range(0, 70) : $urandom_range(0, y), $urandom_range(0, 3));
        end
      end
      ref_model(y);
      run_scan(y, 0, 0);
      check_scan($sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
